// File: rtl/stack_sequencer_if.sv
// Command, response and stack-side signal bundle for stack_sequencer.
// Latency: none, wires only.
// Backpressure: cmd_valid/cmd_ready handshake; the response is an unthrottled one-cycle pulse.
//
// Ports (grouped):
//   cmd_*  : command in (valid/ready, op code, immediate)
//   rsp_*  : response out (valid pulse, top-of-stack data, error code)
//   stk_*  : micro-op port toward the operand stack, plus its TOS and error feedback
//   depth  : shadow entry count kept by the sequencer
// Modports:
//   slave  : the sequencer side.
//   master : the command source together with the stack.
interface stack_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_imm;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic [1:0]       rsp_err;
  logic [1:0]       stk_op;
  logic [WIDTH-1:0] stk_data;
  logic [WIDTH-1:0] stk_tos;
  logic [1:0]       stk_error;
  logic [DEPTH:0]   depth;

  modport slave (
    input  cmd_valid, cmd_op, cmd_imm, stk_tos, stk_error,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, stk_op, stk_data, depth
  );

  modport master (
    output cmd_valid, cmd_op, cmd_imm, stk_tos, stk_error,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, stk_op, stk_data, depth
  );
endinterface

// File: rtl/stack_sequencer.sv
// Expands stack commands (push/drop/dup/peek/add/sub/and) into single-cycle stack micro-ops.
// Latency: 1 cycle to the response when no micro-op is needed, 2 for push/drop/dup, 3 for binary ops.
// Backpressure: accepts only in IDLE, one command in flight; cmd_valid while not ready is ignored.
//
// Ports:
//   clk, reset : clock and synchronous active-high reset (shared with the stack)
//   bus        : stack_sequencer_if.slave carrying cmd_*, rsp_*, stk_* and depth
module stack_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic            clk,
  input  logic            reset,
  stack_sequencer_if.slave bus
);

  localparam int DW = DEPTH + 1;
  // Common width for comparing/subtracting the DROP count against the depth.
  localparam int CW = (WIDTH > DW) ? WIDTH : DW;
  localparam logic [DW-1:0] MAX = {DW{1'b1}};

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_DROP = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_DUP  = 3'd6;
  localparam logic [2:0] OP_PEEK = 3'd7;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_OVER  = 2'd2;
  localparam logic [1:0] ERR_FAULT = 2'd3;

  localparam logic [1:0] SOP_NONE = 2'd0;
  localparam logic [1:0] SOP_PUSH = 2'd1;
  localparam logic [1:0] SOP_POP  = 2'd2;
  localparam logic [1:0] SOP_REPL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_BIN_POP = 3'd2,
    S_BIN_WR  = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] imm_q;
  logic [1:0]       err_q;
  logic             fault_q;
  logic [DW-1:0]    depth_q;
  logic [WIDTH-1:0] a_q;

  logic             accept;
  logic [1:0]       chk_err;
  logic [CW-1:0]    depth_ext;
  logic [CW-1:0]    imm_ext;
  logic [CW-1:0]    drop_rem;
  logic [WIDTH-1:0] alu_res;
  logic             fault_now;

  logic [1:0]       stk_op_c;
  logic [WIDTH-1:0] stk_data_c;
  logic             rsp_valid_c;
  logic [WIDTH-1:0] rsp_data_c;
  logic [1:0]       rsp_err_c;

  assign bus.cmd_ready = (state_q == S_IDLE) && !reset;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  // Legality of the offered command against the shadow depth.
  always_comb begin
    chk_err   = ERR_NONE;
    depth_ext = CW'(depth_q);
    imm_ext   = CW'(bus.cmd_imm);
    case (bus.cmd_op)
      OP_PUSH: begin
        if (depth_q == MAX) chk_err = ERR_OVER;
      end
      OP_DUP: begin
        // Underflow takes priority over overflow.
        if (depth_q == '0)       chk_err = ERR_UNDER;
        else if (depth_q == MAX) chk_err = ERR_OVER;
      end
      OP_DROP: begin
        // cmd_imm is count-1, so we need strictly more entries than imm.
        if (!(depth_ext > imm_ext)) chk_err = ERR_UNDER;
      end
      OP_ADD, OP_SUB, OP_AND: begin
        if (depth_q < DW'(2)) chk_err = ERR_UNDER;
      end
      OP_PEEK: begin
        if (depth_q == '0) chk_err = ERR_UNDER;
      end
      default: chk_err = ERR_NONE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (chk_err != ERR_NONE || bus.cmd_op == OP_NOP || bus.cmd_op == OP_PEEK)
            state_d = S_RESP;
          else if (bus.cmd_op == OP_PUSH || bus.cmd_op == OP_DROP || bus.cmd_op == OP_DUP)
            state_d = S_ISSUE;
          else
            state_d = S_BIN_POP;
        end
      end
      S_ISSUE:   state_d = S_RESP;
      S_BIN_POP: state_d = S_BIN_WR;
      S_BIN_WR:  state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Remaining depth after dropping imm+1 entries; legality guarantees no wrap.
  always_comb begin
    drop_rem = CW'(depth_q) - CW'(imm_q) - CW'(1);
  end

  // Second operand b is the new TOS after popping a; result replaces b.
  always_comb begin
    case (op_q)
      OP_ADD:  alu_res = bus.stk_tos + a_q;
      OP_SUB:  alu_res = bus.stk_tos - a_q;
      OP_AND:  alu_res = bus.stk_tos & a_q;
      default: alu_res = '0;
    endcase
  end

  // Command latch, shadow depth, popped operand and fault latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= OP_NOP;
      imm_q   <= '0;
      err_q   <= ERR_NONE;
      fault_q <= 1'b0;
      depth_q <= '0;
      a_q     <= '0;
    end else begin
      if (accept) begin
        op_q    <= bus.cmd_op;
        imm_q   <= bus.cmd_imm;
        err_q   <= chk_err;
        fault_q <= 1'b0;
      end
      case (state_q)
        S_ISSUE: begin
          if (op_q == OP_DROP) depth_q <= drop_rem[DW-1:0];
          else                 depth_q <= depth_q + DW'(1);
        end
        S_BIN_POP: begin
          a_q     <= bus.stk_tos;
          depth_q <= depth_q - DW'(1);
        end
        S_BIN_WR, S_RESP: begin
          // The stack flags errors a cycle late; any flag here means the
          // shadow depth disagreed with the stack. Depth is left as is.
          if (bus.stk_error != 2'd0) fault_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A fault flagged during RESP itself must still be reported by this response.
  assign fault_now = fault_q || (bus.stk_error != 2'd0);

  // Output decode.
  always_comb begin
    stk_op_c    = SOP_NONE;
    stk_data_c  = '0;
    rsp_valid_c = 1'b0;
    rsp_data_c  = '0;
    rsp_err_c   = ERR_NONE;
    case (state_q)
      S_ISSUE: begin
        if (op_q == OP_DROP) begin
          stk_op_c   = SOP_POP;
          stk_data_c = imm_q;
        end else if (op_q == OP_DUP) begin
          stk_op_c   = SOP_PUSH;
          stk_data_c = bus.stk_tos;
        end else begin
          stk_op_c   = SOP_PUSH;
          stk_data_c = imm_q;
        end
      end
      S_BIN_POP: begin
        stk_op_c = SOP_POP;
      end
      S_BIN_WR: begin
        stk_op_c   = SOP_REPL;
        stk_data_c = alu_res;
      end
      S_RESP: begin
        rsp_valid_c = 1'b1;
        rsp_err_c   = fault_now ? ERR_FAULT : err_q;
        if (rsp_err_c == ERR_NONE && depth_q != '0) rsp_data_c = bus.stk_tos;
      end
      default: ;
    endcase
  end

  // The stack resets in the same cycle, so no micro-op may escape during reset.
  assign bus.stk_op    = reset ? SOP_NONE : stk_op_c;
  assign bus.stk_data  = stk_data_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_data  = rsp_data_c;
  assign bus.rsp_err   = rsp_err_c;
  assign bus.depth     = depth_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a behavioural 15-entry operand stack.
// Drives and samples on the falling clock edge; latencies counted in cycles after accept.
// Stack error feedback can be forced to emulate a stack fault.
module tb_stack_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic inject = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  stack_sequencer_if #(.WIDTH(8), .DEPTH(3)) bus ();

  stack_sequencer #(.WIDTH(8), .DEPTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural operand stack: combinational TOS, error registered one cycle late.
  logic [7:0] smem [0:15];
  int         sp;
  logic [1:0] serr;

  always @(posedge clk) begin
    if (reset) begin
      sp   <= 0;
      serr <= 2'd0;
    end else begin
      serr <= 2'd0;
      case (bus.stk_op)
        2'd1: if (sp == 15) serr <= 2'd2; else begin smem[sp] <= bus.stk_data; sp <= sp + 1; end
        2'd2: if (sp == 0) serr <= 2'd1; else sp <= sp - 1;
        2'd3: if (sp == 0) serr <= 2'd1; else smem[sp-1] <= bus.stk_data;
        default: ;
      endcase
    end
  end

  assign bus.stk_tos   = (sp > 0) ? smem[sp-1] : 8'h00;
  assign bus.stk_error = inject ? 2'd3 : serr;

  logic [1:0] log_op  [1:3];
  logic [7:0] log_dat [1:3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command, wait for its response, check latency/data/error and the pulse width.
  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [7:0] imm,
                        input logic [7:0] exp_data, input logic [1:0] exp_err, input int exp_lat);
    int n;
    bit got;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, " rdy"}, bus.cmd_ready, 1);
    for (int i = 1; i <= 3; i++) begin log_op[i] = 2'd0; log_dat[i] = 8'h00; end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_imm   = imm;
    got = 1'b0;
    n = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      // Garbage on the fields after accept must not matter.
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'd1;
      bus.cmd_imm   = 8'hA5;
      n++;
      if (n <= 3) begin log_op[n] = bus.stk_op; log_dat[n] = bus.stk_data; end
      if (bus.rsp_valid) got = 1'b1;
    end
    chk({tag, " lat"}, n, exp_lat);
    chk({tag, " data"}, bus.rsp_data, exp_data);
    chk({tag, " err"}, bus.rsp_err, exp_err);
    @(negedge clk);
    chk({tag, " pulse"}, bus.rsp_valid, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_imm   = 8'h00;

    // Reset values while reset is held.
    @(negedge clk);
    @(negedge clk);
    chk("rst cmd_ready", bus.cmd_ready, 0);
    chk("rst rsp_valid", bus.rsp_valid, 0);
    chk("rst rsp_data", bus.rsp_data, 0);
    chk("rst rsp_err", bus.rsp_err, 0);
    chk("rst stk_op", bus.stk_op, 0);
    chk("rst stk_data", bus.stk_data, 0);
    chk("rst depth", bus.depth, 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic SUB: 5 - 3.
    do_cmd("push5", 3'd1, 8'h05, 8'h05, 2'd0, 2);
    chk("push5 op", log_op[1], 1);
    chk("push5 dat", log_dat[1], 8'h05);
    do_cmd("push3", 3'd1, 8'h03, 8'h03, 2'd0, 2);
    do_cmd("sub", 3'd4, 8'h00, 8'h02, 2'd0, 3);
    chk("sub pop", log_op[1], 2);
    chk("sub repl", log_op[2], 3);
    chk("sub repl dat", log_dat[2], 8'h02);
    chk("sub depth", bus.depth, 1);

    // Binary underflow at depth 1.
    do_cmd("add udf", 3'd3, 8'h00, 8'h00, 2'd1, 1);
    chk("add udf op", log_op[1], 0);
    chk("add udf depth", bus.depth, 1);

    // Overflow.
    do_reset();
    for (int i = 0; i < 15; i++) do_cmd("fill", 3'd1, 8'(i + 1), 8'(i + 1), 2'd0, 2);
    chk("full depth", bus.depth, 15);
    do_cmd("push ovf", 3'd1, 8'h40, 8'h00, 2'd2, 1);
    chk("push ovf op", log_op[1], 0);
    chk("push ovf depth", bus.depth, 15);
    do_cmd("dup ovf", 3'd6, 8'h00, 8'h00, 2'd2, 1);
    do_cmd("peek full", 3'd7, 8'h00, 8'h0F, 2'd0, 1);

    // DROP.
    do_reset();
    do_cmd("p1", 3'd1, 8'h01, 8'h01, 2'd0, 2);
    do_cmd("p2", 3'd1, 8'h02, 8'h02, 2'd0, 2);
    do_cmd("p3", 3'd1, 8'h03, 8'h03, 2'd0, 2);
    do_cmd("drop3", 3'd2, 8'h02, 8'h00, 2'd0, 2);
    chk("drop3 op", log_op[1], 2);
    chk("drop3 dat", log_dat[1], 8'h02);
    chk("drop3 depth", bus.depth, 0);
    do_cmd("drop udf", 3'd2, 8'h00, 8'h00, 2'd1, 1);

    // Wrap-around arithmetic.
    do_cmd("pff", 3'd1, 8'hFF, 8'hFF, 2'd0, 2);
    do_cmd("p02", 3'd1, 8'h02, 8'h02, 2'd0, 2);
    do_cmd("add wrap", 3'd3, 8'h00, 8'h01, 2'd0, 3);
    do_cmd("pf0", 3'd1, 8'hF0, 8'hF0, 2'd0, 2);
    do_cmd("and", 3'd5, 8'h00, 8'h00, 2'd0, 3);
    chk("and depth", bus.depth, 1);
    do_cmd("p00", 3'd1, 8'h00, 8'h00, 2'd0, 2);
    do_cmd("p01", 3'd1, 8'h01, 8'h01, 2'd0, 2);
    do_cmd("sub wrap", 3'd4, 8'h00, 8'hFF, 2'd0, 3);
    chk("sub wrap depth", bus.depth, 2);

    // DUP and NOP.
    do_cmd("dup", 3'd6, 8'h00, 8'hFF, 2'd0, 2);
    chk("dup op", log_op[1], 1);
    chk("dup dat", log_dat[1], 8'hFF);
    chk("dup depth", bus.depth, 3);
    do_cmd("nop", 3'd0, 8'h00, 8'hFF, 2'd0, 1);

    // Stack fault reported as err 3; depth not corrected; latch clears on next accept.
    inject = 1'b1;
    do_cmd("fault", 3'd1, 8'h11, 8'h00, 2'd3, 2);
    inject = 1'b0;
    chk("fault depth", bus.depth, 4);
    do_cmd("post fault", 3'd0, 8'h00, 8'h11, 2'd0, 1);

    // Reset during BIN_POP of an ADD.
    do_reset();
    do_cmd("r p1", 3'd1, 8'h01, 8'h01, 2'd0, 2);
    do_cmd("r p2", 3'd1, 8'h02, 8'h02, 2'd0, 2);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd3;
    bus.cmd_imm   = 8'h00;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst stk_op", bus.stk_op, 0);
    chk("midrst rsp_valid", bus.rsp_valid, 0);
    @(negedge clk);
    chk("midrst ready", bus.cmd_ready, 0);
    chk("midrst rsp_valid2", bus.rsp_valid, 0);
    chk("midrst depth", bus.depth, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("after rst ready", bus.cmd_ready, 1);
    chk("after rst rsp_valid", bus.rsp_valid, 0);
    chk("after rst depth", bus.depth, 0);
    do_cmd("peek empty", 3'd7, 8'h00, 8'h00, 2'd1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
